// File: rtl/cordic_pkg.sv
// Shared defaults and tag type for the CORDIC requester arbiter.
// Holds widths, latency defaults and the tag-line record.
package cordic_pkg;

  localparam int DW_D   = 16;
  localparam int LAT_D  = 18;
  localparam int NREQ_D = 4;
  localparam int IDW    = $clog2(NREQ_D);

  // wide enough for up to 8 requesters
  localparam int TAGW = 3;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_arbiter_rr.sv
// Round-robin arbiter: pointer, rotated priority scan, one-hot grant.
// Ports: clk, rst, req, hold -> grant (one-hot), grant_id.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] idx;
  logic          found;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  // scan ptr, ptr+1, ... and take the first requester
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (!hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = wrap(int'(ptr) + k);
        if (!found && req[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = idx;
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (found) begin
      if (grant_id == IW'(NREQ - 1))
        ptr_nxt = '0;
      else
        ptr_nxt = grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one fixed-latency CORDIC among NREQ requesters with tag routing.
// Ports: req_* in/ready, cor_in_* issue, cor_out_* return, res_* demux, busy, err_orphan.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int NREQ = NREQ_D,
  parameter int LAT  = LAT_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               cor_in_valid,
  output logic [DW-1:0]      cor_in_x,
  output logic [DW-1:0]      cor_in_y,
  input  logic               cor_out_valid,
  input  logic [DW-1:0]      cor_out_mag,
  input  logic [DW-1:0]      cor_out_ang,
  output logic [NREQ-1:0]    res_valid,
  output logic [DW-1:0]      res_mag,
  output logic [DW-1:0]      res_ang,
  output logic               busy,
  output logic               err_orphan
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] gid;
  logic          hs;
  logic [DW-1:0] sel_x;
  logic [DW-1:0] sel_y;
  logic [IW-1:0] in_id;
  tag_t          tl [LAT];
  tag_t          tail;
  logic          any_tag;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .hold     (hold),
    .grant    (req_ready),
    .grant_id (gid)
  );

  // grant is only ever given to an active requester
  assign hs = |req_ready;

  always_comb begin
    sel_x = req_x[int'(gid)*DW +: DW];
    sel_y = req_y[int'(gid)*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cor_in_valid <= 1'b0;
      cor_in_x     <= '0;
      cor_in_y     <= '0;
      in_id        <= '0;
    end else begin
      cor_in_valid <= hs;
      if (hs) begin
        cor_in_x <= sel_x;
        cor_in_y <= sel_y;
        in_id    <= gid;
      end
    end
  end

  // stage 0 captures the issue registers; the last stage
  // lines up with the CORDIC result strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++)
        tl[k] <= '0;
    end else begin
      tl[0].valid <= cor_in_valid;
      tl[0].id    <= TAGW'(in_id);
      for (int k = 1; k < LAT; k++)
        tl[k] <= tl[k-1];
    end
  end

  assign tail = tl[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= '0;
      res_mag    <= '0;
      res_ang    <= '0;
      err_orphan <= 1'b0;
    end else begin
      res_valid <= '0;
      if (cor_out_valid && tail.valid) begin
        res_valid <= NREQ'(1) << tail.id;
        res_mag   <= cor_out_mag;
        res_ang   <= cor_out_ang;
      end
      if (cor_out_valid != tail.valid)
        err_orphan <= 1'b1;
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k < LAT; k++)
      any_tag = any_tag | tl[k].valid;
  end

  assign busy = any_tag | cor_in_valid | (|res_valid);

endmodule
